rtcomp_vc: RTL and testbench

- Per-input-port routing computation unit for the 2D-mesh router with a parametrised mesh size, VC count and routing mode.
- Computes the output port for head flits (dimension-order XY or YX) and holds that route per virtual channel until the tail flit.
- Body and tail flits reuse the held route.
- Output is a one-entry registered pipeline stage with a valid/ready handshake, placed between the input buffer and the VC/switch allocator.

---
 rtl/rtcomp_vc_pkg.sv | 34 +++
 rtl/rtcomp_vc_if.sv | 37 +++
 rtl/rt_dor.sv | 42 ++++
 rtl/rtcomp_vc.sv | 145 ++++++++++++++
 tb/tb_rtcomp_vc.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rtcomp_vc_pkg.sv
// rtcomp_vc_pkg -- flit type, output port and routing mode encodings for rtcomp_vc.
// Revision 1.0
`default_nettype none

package rtcomp_vc_pkg;

  localparam int PORTW = 5;

  localparam logic [1:0] FT_HEAD     = 2'd0;
  localparam logic [1:0] FT_BODY     = 2'd1;
  localparam logic [1:0] FT_TAIL     = 2'd2;
  localparam logic [1:0] FT_HEADTAIL = 2'd3;

  localparam logic [PORTW-1:0] P_LOCAL = 5'b00001;
  localparam logic [PORTW-1:0] P_NORTH = 5'b00010;
  localparam logic [PORTW-1:0] P_EAST  = 5'b00100;
  localparam logic [PORTW-1:0] P_SOUTH = 5'b01000;
  localparam logic [PORTW-1:0] P_WEST  = 5'b10000;

  localparam int RM_XY = 0;
  localparam int RM_YX = 1;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_t;

  function automatic logic ft_is_head(input logic [1:0] ft);
    return (ft == FT_HEAD) || (ft == FT_HEADTAIL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtcomp_vc_if.sv
// rtcomp_vc_if -- flit input and route-result output handshake bundle of rtcomp_vc.
// Revision 1.0
`default_nettype none

interface rtcomp_vc_if
  import rtcomp_vc_pkg::*;
#(
  parameter int XW   = 2,
  parameter int YW   = 2,
  parameter int VCHW = 1
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_ftype;
  logic [VCHW-1:0]  in_vch;
  logic [XW-1:0]    in_dst_x;
  logic [YW-1:0]    in_dst_y;
  logic             out_valid;
  logic             out_ready;
  logic [PORTW-1:0] out_port;
  logic [VCHW-1:0]  out_vch;
  logic [1:0]       out_ftype;

  modport master (
    output in_valid, in_ftype, in_vch, in_dst_x, in_dst_y, out_ready,
    input  in_ready, out_valid, out_port, out_vch, out_ftype
  );

  modport slave (
    input  in_valid, in_ftype, in_vch, in_dst_x, in_dst_y, out_ready,
    output in_ready, out_valid, out_port, out_vch, out_ftype
  );

endinterface

`default_nettype wire

// File: rtl/rt_dor.sv
// rt_dor -- combinational dimension-order (XY / YX) output port decoder.
// Revision 1.0
`default_nettype none

module rt_dor
  import rtcomp_vc_pkg::*;
#(
  parameter int MY_XPOS    = 0,
  parameter int MY_YPOS    = 0,
  parameter int XW         = 2,
  parameter int YW         = 2,
  parameter int ROUTE_MODE = 0
) (
  input  wire logic [XW-1:0]    dst_x,
  input  wire logic [YW-1:0]    dst_y,
  output logic      [PORTW-1:0] port
);

  localparam logic [XW-1:0] c_MY_X = XW'(MY_XPOS);
  localparam logic [YW-1:0] c_MY_Y = YW'(MY_YPOS);

  logic [PORTW-1:0] w_x_port;
  logic [PORTW-1:0] w_y_port;
  logic             w_x_hit;
  logic             w_y_hit;

  assign w_x_hit  = (dst_x != c_MY_X);
  assign w_y_hit  = (dst_y != c_MY_Y);
  assign w_x_port = (dst_x > c_MY_X) ? P_EAST  : P_WEST;
  assign w_y_port = (dst_y > c_MY_Y) ? P_SOUTH : P_NORTH;

  generate
    if (ROUTE_MODE == RM_YX) begin : g_yx
      assign port = w_y_hit ? w_y_port : (w_x_hit ? w_x_port : P_LOCAL);
    end else begin : g_xy
      assign port = w_x_hit ? w_x_port : (w_y_hit ? w_y_port : P_LOCAL);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rtcomp_vc.sv
// rtcomp_vc -- per-input-port route computation with per-VC route hold and a one-entry output stage.
// Revision 1.0; define RTCOMP_ERRCHK_EN to drop protocol-violating flits and pulse err.
`default_nettype none

module rtcomp_vc
  import rtcomp_vc_pkg::*;
#(
  parameter int MY_XPOS    = 0,
  parameter int MY_YPOS    = 0,
  parameter int XW         = 2,
  parameter int YW         = 2,
  parameter int VCH        = 2,
  parameter int VCHW       = 1,
  parameter int ROUTE_MODE = 0
) (
  input  wire logic   clk,
  input  wire logic   rst_,
  rtcomp_vc_if.slave  bus
`ifdef RTCOMP_ERRCHK_EN
  ,
  output logic        err
`endif
);

  vc_state_t        r_vc_state     [VCH];
  vc_state_t        w_vc_state_nxt [VCH];
  logic [PORTW-1:0] r_route_tbl    [VCH];

  logic             r_out_valid;
  logic [PORTW-1:0] r_out_port;
  logic [VCHW-1:0]  r_out_vch;
  logic [1:0]       r_out_ftype;

  logic             w_accept;
  logic             w_is_head;
  logic             w_drop;
  logic             w_load;
  logic [PORTW-1:0] w_route;
  logic [PORTW-1:0] w_tbl_sel;
  logic [PORTW-1:0] w_port_sel;

  rt_dor #(
    .MY_XPOS    (MY_XPOS),
    .MY_YPOS    (MY_YPOS),
    .XW         (XW),
    .YW         (YW),
    .ROUTE_MODE (ROUTE_MODE)
  ) u_rt_dor (
    .dst_x (bus.in_dst_x),
    .dst_y (bus.in_dst_y),
    .port  (w_route)
  );

  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_is_head    = ft_is_head(bus.in_ftype);

  // Loop-compare rather than direct indexing keeps out-of-range VC codes harmless.
  always_comb begin
    w_tbl_sel = '0;
    for (int v = 0; v < VCH; v++) begin
      if (bus.in_vch == VCHW'(v)) w_tbl_sel = r_route_tbl[v];
    end
  end

`ifdef RTCOMP_ERRCHK_EN
  vc_state_t w_cur_state;
  logic      r_err;

  always_comb begin
    w_cur_state = VC_IDLE;
    for (int v = 0; v < VCH; v++) begin
      if (bus.in_vch == VCHW'(v)) w_cur_state = r_vc_state[v];
    end
  end

  assign w_drop = w_accept && (w_is_head ? (w_cur_state == VC_ACTIVE)
                                         : (w_cur_state == VC_IDLE));

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) r_err <= 1'b0;
    else      r_err <= w_drop;
  end

  assign err = r_err;
`else
  assign w_drop = 1'b0;
`endif

  assign w_load     = w_accept && !w_drop;
  assign w_port_sel = w_is_head ? w_route : w_tbl_sel;

  always_comb begin
    for (int v = 0; v < VCH; v++) begin
      w_vc_state_nxt[v] = r_vc_state[v];
      if (w_load && (bus.in_vch == VCHW'(v))) begin
        case (bus.in_ftype)
          FT_HEAD:     w_vc_state_nxt[v] = VC_ACTIVE;
          FT_TAIL:     w_vc_state_nxt[v] = VC_IDLE;
          FT_HEADTAIL: w_vc_state_nxt[v] = VC_IDLE;
          default:     w_vc_state_nxt[v] = r_vc_state[v];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int v = 0; v < VCH; v++) begin
        r_vc_state[v]  <= VC_IDLE;
        r_route_tbl[v] <= '0;
      end
    end else begin
      for (int v = 0; v < VCH; v++) begin
        r_vc_state[v] <= w_vc_state_nxt[v];
        if (w_load && w_is_head && (bus.in_vch == VCHW'(v))) r_route_tbl[v] <= w_route;
      end
    end
  end

  // A dropped flit can only be accepted while the stage drains, so out_ready alone clears it.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_out_valid <= 1'b0;
      r_out_port  <= '0;
      r_out_vch   <= '0;
      r_out_ftype <= FT_HEAD;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_port  <= w_port_sel;
      r_out_vch   <= bus.in_vch;
      r_out_ftype <= bus.in_ftype;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_port  = r_out_port;
  assign bus.out_vch   = r_out_vch;
  assign bus.out_ftype = r_out_ftype;

endmodule

`default_nettype wire

// File: tb/tb_rtcomp_vc.sv
// tb_rtcomp_vc -- drives an XY and a YX instance at node (1,1) in lockstep against a behavioural model.
// Revision 1.0
`default_nettype none

module tb_rtcomp_vc;
  import rtcomp_vc_pkg::*;

  localparam int XW   = 2;
  localparam int YW   = 2;
  localparam int VCH  = 2;
  localparam int VCHW = 1;
  localparam int MYX  = 1;
  localparam int MYY  = 1;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  rtcomp_vc_if #(.XW(XW), .YW(YW), .VCHW(VCHW)) bxy ();
  rtcomp_vc_if #(.XW(XW), .YW(YW), .VCHW(VCHW)) byx ();

`ifdef RTCOMP_ERRCHK_EN
  logic err_xy;
  logic err_yx;
  logic m_err;
`endif

  rtcomp_vc #(
    .MY_XPOS(MYX), .MY_YPOS(MYY), .XW(XW), .YW(YW),
    .VCH(VCH), .VCHW(VCHW), .ROUTE_MODE(0)
  ) dut_xy (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bxy)
`ifdef RTCOMP_ERRCHK_EN
    ,
    .err  (err_xy)
`endif
  );

  rtcomp_vc #(
    .MY_XPOS(MYX), .MY_YPOS(MYY), .XW(XW), .YW(YW),
    .VCH(VCH), .VCHW(VCHW), .ROUTE_MODE(1)
  ) dut_yx (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (byx)
`ifdef RTCOMP_ERRCHK_EN
    ,
    .err  (err_yx)
`endif
  );

  // Reference model: index 0 = XY instance, 1 = YX instance.
  bit              m_act [VCH];
  logic [4:0]      m_tbl [2][VCH];
  logic            m_valid;
  logic [4:0]      m_port [2];
  logic [VCHW-1:0] m_vch;
  logic [1:0]      m_ft;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [4:0] ref_route(input int mode, input int dx, input int dy);
    logic [4:0] px;
    logic [4:0] py;
    px = (dx > MYX) ? 5'b00100 : ((dx < MYX) ? 5'b10000 : 5'b00000);
    py = (dy > MYY) ? 5'b01000 : ((dy < MYY) ? 5'b00010 : 5'b00000);
    if (mode == 0) return (px != 0) ? px : ((py != 0) ? py : 5'b00001);
    else           return (py != 0) ? py : ((px != 0) ? px : 5'b00001);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int v = 0; v < VCH; v++) begin
      m_act[v]    = 1'b0;
      m_tbl[0][v] = '0;
      m_tbl[1][v] = '0;
    end
    m_valid   = 1'b0;
    m_port[0] = '0;
    m_port[1] = '0;
    m_vch     = '0;
    m_ft      = '0;
`ifdef RTCOMP_ERRCHK_EN
    m_err     = 1'b0;
`endif
  endtask

  task automatic check_outs(input string ph);
    check({ph, ".xy.valid"}, 32'(bxy.out_valid), 32'(m_valid));
    check({ph, ".yx.valid"}, 32'(byx.out_valid), 32'(m_valid));
    check({ph, ".xy.port"},  32'(bxy.out_port),  32'(m_port[0]));
    check({ph, ".yx.port"},  32'(byx.out_port),  32'(m_port[1]));
    check({ph, ".xy.vch"},   32'(bxy.out_vch),   32'(m_vch));
    check({ph, ".yx.vch"},   32'(byx.out_vch),   32'(m_vch));
    check({ph, ".xy.ftype"}, 32'(bxy.out_ftype), 32'(m_ft));
    check({ph, ".yx.ftype"}, 32'(byx.out_ftype), 32'(m_ft));
`ifdef RTCOMP_ERRCHK_EN
    check({ph, ".xy.err"},   32'(err_xy),        32'(m_err));
    check({ph, ".yx.err"},   32'(err_yx),        32'(m_err));
`endif
  endtask

  task automatic drive(input bit v, input logic [1:0] ft, input int vc,
                       input int dx, input int dy, input bit ordy);
    bxy.in_valid = v;  byx.in_valid = v;
    bxy.in_ftype = ft; byx.in_ftype = ft;
    bxy.in_vch   = VCHW'(vc); byx.in_vch = VCHW'(vc);
    bxy.in_dst_x = XW'(dx);   byx.in_dst_x = XW'(dx);
    bxy.in_dst_y = YW'(dy);   byx.in_dst_y = YW'(dy);
    bxy.out_ready = ordy; byx.out_ready = ordy;
  endtask

  // One clock of stimulus: check in_ready, clock, advance the model, check outputs.
  task automatic cycle(input string ph, input bit v, input logic [1:0] ft, input int vc,
                       input int dx, input int dy, input bit ordy);
    bit exp_rdy;
    bit acc;
    bit drop;
    bit head;
    drive(v, ft, vc, dx, dy, ordy);
    #3;
    exp_rdy = !m_valid || ordy;
    check({ph, ".xy.in_ready"}, 32'(bxy.in_ready), 32'(exp_rdy));
    check({ph, ".yx.in_ready"}, 32'(byx.in_ready), 32'(exp_rdy));
    @(posedge clk);
    acc  = v && exp_rdy;
    head = (ft == 2'd0) || (ft == 2'd3);
    drop = 1'b0;
`ifdef RTCOMP_ERRCHK_EN
    if (acc) drop = head ? m_act[vc] : !m_act[vc];
    m_err = acc && drop;
`endif
    if (acc && !drop) begin
      for (int m = 0; m < 2; m++) begin
        if (head) m_tbl[m][vc] = ref_route(m, dx, dy);
        m_port[m] = m_tbl[m][vc];
      end
      if (ft == 2'd0)      m_act[vc] = 1'b1;
      else if (ft != 2'd1) m_act[vc] = 1'b0;
      m_valid = 1'b1;
      m_vch   = VCHW'(vc);
      m_ft    = ft;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check_outs(ph);
  endtask

  initial begin
    model_reset();
    drive(1'b0, 2'd0, 0, 0, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    rst_ = 1'b0;

    cycle("head_east",   1, FT_HEAD,     0, 3, 1, 1);
    cycle("tail_east",   1, FT_TAIL,     0, 0, 0, 1);
    cycle("head_north",  1, FT_HEAD,     0, 3, 0, 1);
    cycle("tail_north",  1, FT_TAIL,     0, 2, 2, 1);
    cycle("ht_local",    1, FT_HEADTAIL, 0, 1, 1, 1);

    cycle("il_h0_west",  1, FT_HEAD,     0, 0, 1, 1);
    cycle("il_h1_south", 1, FT_HEAD,     1, 1, 3, 1);
    cycle("il_b0",       1, FT_BODY,     0, 3, 3, 1);
    cycle("il_b1",       1, FT_BODY,     1, 0, 0, 1);
    cycle("il_t0",       1, FT_TAIL,     0, 3, 0, 1);
    cycle("il_t1",       1, FT_TAIL,     1, 0, 3, 1);

    cycle("bp_head",     1, FT_HEAD,     0, 2, 2, 1);
    for (int i = 0; i < 3; i++) cycle("bp_stall", 1, FT_BODY, 0, 0, 0, 0);
    cycle("bp_release",  1, FT_BODY,     0, 0, 0, 1);
    cycle("bp_tail",     1, FT_TAIL,     0, 0, 0, 1);
    cycle("drain",       0, FT_HEAD,     0, 0, 0, 1);

    cycle("rst_head",    1, FT_HEAD,     0, 0, 0, 1);
    #2 rst_ = 1'b1;
    #1;
    model_reset();
    check_outs("async_rst");
    #1 rst_ = 1'b0;
    cycle("post_rst_body", 1, FT_BODY,   0, 3, 3, 1);
    cycle("post_rst_idle", 0, FT_HEAD,   0, 0, 0, 1);

    cycle("dbl_head1",   1, FT_HEAD,     1, 3, 3, 1);
    cycle("dbl_head2",   1, FT_HEAD,     1, 0, 0, 1);
    cycle("dbl_body",    1, FT_BODY,     1, 2, 0, 1);
    cycle("dbl_tail",    1, FT_TAIL,     1, 1, 2, 1);
    cycle("dbl_idle",    0, FT_HEAD,     0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(0, 9) < 8),
            2'($urandom_range(0, 3)),
            int'($urandom_range(0, VCH - 1)),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
